// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
//   Main control sequencer for the multi-cycle MIPS datapath. It steps one state
//   per clock through fetch, decode, execute, memory and write-back, drives every
//   datapath strobe and mux select, and holds in the memory states until the
//   memory returns mem_ready.
//
//   Optional feature macro: MC_CTRL_ADDI_EN
//     defined     -> addi (opcode 001000) is decoded through ADDI_EX / ADDI_WB
//     not defined -> addi is reported as an illegal opcode like any other
// -----------------------------------------------------------------------------
module mc_control_fsm #(
   parameter int ST_W = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [5:0]      opcode,
   input  logic            mem_ready,
   output logic            pc_write,
   output logic            pc_write_cond,
   output logic            i_or_d,
   output logic            mem_read,
   output logic            mem_write,
   output logic            ir_write,
   output logic            mem_to_reg,
   output logic            reg_dst,
   output logic            reg_write,
   output logic            alu_src_a,
   output logic [1:0]      alu_src_b,
   output logic [1:0]      alu_op,
   output logic [1:0]      pc_source,
   output logic            illegal_op,
   output logic [ST_W-1:0] state_dbg
);

   // State encodings; these values are visible on state_dbg, so they are fixed.
   localparam logic [ST_W-1:0] FETCH    = ST_W'(0);
   localparam logic [ST_W-1:0] DECODE   = ST_W'(1);
   localparam logic [ST_W-1:0] MEM_ADDR = ST_W'(2);
   localparam logic [ST_W-1:0] MEM_RD   = ST_W'(3);
   localparam logic [ST_W-1:0] MEM_WB   = ST_W'(4);
   localparam logic [ST_W-1:0] MEM_WR   = ST_W'(5);
   localparam logic [ST_W-1:0] EXEC_R   = ST_W'(6);
   localparam logic [ST_W-1:0] R_WB     = ST_W'(7);
   localparam logic [ST_W-1:0] BRANCH   = ST_W'(8);
   localparam logic [ST_W-1:0] JUMP     = ST_W'(9);
`ifdef MC_CTRL_ADDI_EN
   localparam logic [ST_W-1:0] ADDI_EX  = ST_W'(10);
   localparam logic [ST_W-1:0] ADDI_WB  = ST_W'(11);
`endif

   // Opcodes understood by the decoder.
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_ADDI_EN
   localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

   logic [ST_W-1:0] state;
   logic [ST_W-1:0] nextState;
   logic            opIllegal;

   // State register: async reset abandons whatever instruction was in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic; also flags an unsupported opcode while sitting in DECODE.
   // The flag is a decode of the current state, so it is naturally a single-cycle
   // pulse and is forced low by reset along with the state.
   always_comb begin
      nextState = FETCH;
      opIllegal = 1'b0;
      case (state)
         FETCH:    nextState = mem_ready ? DECODE : FETCH;
         DECODE: begin
            case (opcode)
               OP_RTYPE:      nextState = EXEC_R;
               OP_LW, OP_SW:  nextState = MEM_ADDR;
               OP_BEQ:        nextState = BRANCH;
               OP_J:          nextState = JUMP;
`ifdef MC_CTRL_ADDI_EN
               OP_ADDI:       nextState = ADDI_EX;
`endif
               default: begin
                  nextState = FETCH;
                  opIllegal = 1'b1;
               end
            endcase
         end
         MEM_ADDR: begin
            if (opcode == OP_LW) begin
               nextState = MEM_RD;
            end else if (opcode == OP_SW) begin
               nextState = MEM_WR;
            end else begin
               nextState = FETCH;
            end
         end
         MEM_RD:   nextState = mem_ready ? MEM_WB : MEM_RD;
         MEM_WB:   nextState = FETCH;
         MEM_WR:   nextState = mem_ready ? FETCH : MEM_WR;
         EXEC_R:   nextState = R_WB;
         R_WB:     nextState = FETCH;
         BRANCH:   nextState = FETCH;
         JUMP:     nextState = FETCH;
`ifdef MC_CTRL_ADDI_EN
         ADDI_EX:  nextState = ADDI_WB;
         ADDI_WB:  nextState = FETCH;
`endif
         default:  nextState = FETCH;
      endcase
   end

   // Moore output decode; only the fetch-stage IR and PC loads look at mem_ready,
   // so a stalled fetch keeps reading without committing anything.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'd0;
      alu_op        = 2'd0;
      pc_source     = 2'd0;
      case (state)
         FETCH: begin
            mem_read  = 1'b1;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            alu_src_b = 2'd1;
         end
         DECODE: begin
            alu_src_b = 2'd3;
         end
         MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
         end
         MEM_RD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            reg_dst    = 1'b1;
         end
         MEM_WR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         EXEC_R: begin
            alu_src_a = 1'b1;
            alu_op    = 2'd2;
         end
         R_WB: begin
            reg_write = 1'b1;
         end
         BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'd1;
            pc_write_cond = 1'b1;
            pc_source     = 2'd1;
         end
         JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'd2;
         end
`ifdef MC_CTRL_ADDI_EN
         ADDI_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
         end
         ADDI_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
`endif
         default: begin
         end
      endcase
   end

   assign illegal_op = opIllegal;
   assign state_dbg  = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_control_fsm
//   Self-checking bench for mc_control_fsm. For every instruction it builds the
//   expected list of visited states (including stall cycles) from the opcode and
//   the chosen memory delays, then walks the DUT through it cycle by cycle and
//   compares state_dbg and every control output. Honours MC_CTRL_ADDI_EN.
// -----------------------------------------------------------------------------
module tb_mc_control_fsm;

   logic       clk;
   logic       reset;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pc_write;
   logic       pc_write_cond;
   logic       i_or_d;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       mem_to_reg;
   logic       reg_dst;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] pc_source;
   logic       illegal_op;
   logic [3:0] state_dbg;

   typedef struct packed {
      logic       pcWrite;
      logic       pcWriteCond;
      logic       iOrD;
      logic       memRead;
      logic       memWrite;
      logic       irWrite;
      logic       memToReg;
      logic       regDst;
      logic       regWrite;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] aluOp;
      logic [1:0] pcSource;
      logic       illegalOp;
   } ctrl_t;

   typedef struct {
      int unsigned st;
      bit          rdy;
   } step_t;

   step_t plan[$];
   int    passCount  = 0;
   int    failCount  = 0;
   int    totalCount = 0;

   mc_control_fsm #(.ST_W(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .opcode       (opcode),
      .mem_ready    (mem_ready),
      .pc_write     (pc_write),
      .pc_write_cond(pc_write_cond),
      .i_or_d       (i_or_d),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .ir_write     (ir_write),
      .mem_to_reg   (mem_to_reg),
      .reg_dst      (reg_dst),
      .reg_write    (reg_write),
      .alu_src_a    (alu_src_a),
      .alu_src_b    (alu_src_b),
      .alu_op       (alu_op),
      .pc_source    (pc_source),
      .illegal_op   (illegal_op),
      .state_dbg    (state_dbg)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Which opcodes the decoder is expected to accept in this build.
   function automatic bit isSupported(logic [5:0] op);
      bit ok;
      ok = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
           (op == 6'b000100) || (op == 6'b000010);
`ifdef MC_CTRL_ADDI_EN
      ok = ok || (op == 6'b001000);
`endif
      return ok;
   endfunction

   // Control word the datapath should see in a given state.
   function automatic ctrl_t expectedControls(int unsigned st, bit rdy, logic [5:0] op);
      ctrl_t c;
      c = '0;
      case (st)
         0:  begin c.memRead = 1'b1; c.irWrite = rdy; c.pcWrite = rdy; c.aluSrcB = 2'd1; end
         1:  begin c.aluSrcB = 2'd3; c.illegalOp = !isSupported(op); end
         2:  begin c.aluSrcA = 1'b1; c.aluSrcB = 2'd2; end
         3:  begin c.memRead = 1'b1; c.iOrD = 1'b1; end
         4:  begin c.regWrite = 1'b1; c.memToReg = 1'b1; c.regDst = 1'b1; end
         5:  begin c.memWrite = 1'b1; c.iOrD = 1'b1; end
         6:  begin c.aluSrcA = 1'b1; c.aluOp = 2'd2; end
         7:  begin c.regWrite = 1'b1; end
         8:  begin c.aluSrcA = 1'b1; c.aluOp = 2'd1; c.pcWriteCond = 1'b1; c.pcSource = 2'd1; end
         9:  begin c.pcWrite = 1'b1; c.pcSource = 2'd2; end
         10: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'd2; end
         11: begin c.regWrite = 1'b1; c.regDst = 1'b1; end
         default: begin end
      endcase
      return c;
   endfunction

   // Snapshot of the DUT outputs in the same layout as ctrl_t.
   function automatic ctrl_t observedControls();
      return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
              mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
              pc_source, illegal_op};
   endfunction

   // One comparison: counts it and reports any difference.
   task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
      totalCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected state walk for one instruction: fetch (with stalls), decode, then
   // the opcode-specific tail, each memory state repeated once per stall cycle.
   task automatic buildPlan(logic [5:0] op, int fetchStalls, int memStalls);
      plan.delete();
      for (int i = 0; i < fetchStalls; i++) plan.push_back('{0, 1'b0});
      plan.push_back('{0, 1'b1});
      plan.push_back('{1, 1'($urandom)});
      case (op)
         6'b000000: begin
            plan.push_back('{6, 1'($urandom)});
            plan.push_back('{7, 1'($urandom)});
         end
         6'b100011: begin
            plan.push_back('{2, 1'($urandom)});
            for (int i = 0; i < memStalls; i++) plan.push_back('{3, 1'b0});
            plan.push_back('{3, 1'b1});
            plan.push_back('{4, 1'($urandom)});
         end
         6'b101011: begin
            plan.push_back('{2, 1'($urandom)});
            for (int i = 0; i < memStalls; i++) plan.push_back('{5, 1'b0});
            plan.push_back('{5, 1'b1});
         end
         6'b000100: plan.push_back('{8, 1'($urandom)});
         6'b000010: plan.push_back('{9, 1'($urandom)});
`ifdef MC_CTRL_ADDI_EN
         6'b001000: begin
            plan.push_back('{10, 1'($urandom)});
            plan.push_back('{11, 1'($urandom)});
         end
`endif
         default: begin end
      endcase
   endtask

   // Drive the plan; entered and left at one time unit after a rising edge.
   // abortAt >= 0 asserts reset mid-cycle after that step and checks the bail-out.
   task automatic applyStimulus(string name, logic [5:0] op, int abortAt);
      for (int i = 0; i < plan.size(); i++) begin
         opcode    = op;
         mem_ready = plan[i].rdy;
         #2;
         checkOutput($sformatf("%s step%0d state", name, i), 32'(state_dbg), plan[i].st);
         checkOutput($sformatf("%s step%0d ctrl", name, i), 32'(observedControls()),
                     32'(expectedControls(plan[i].st, plan[i].rdy, op)));
         if (i == abortAt) begin
            #1;
            mem_ready = 1'b0;
            reset     = 1'b1;
            #1;
            checkOutput($sformatf("%s abort state", name), 32'(state_dbg), 0);
            checkOutput($sformatf("%s abort ctrl", name), 32'(observedControls()),
                        32'(expectedControls(0, 1'b0, op)));
            #1;
            reset = 1'b0;
            @(posedge clk);
            #1;
            return;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic runInstr(string name, logic [5:0] op, int fetchStalls, int memStalls,
                           int expectedLen);
      buildPlan(op, fetchStalls, memStalls);
      if (expectedLen > 0) begin
         checkOutput($sformatf("%s latency", name), plan.size(), expectedLen);
      end
      applyStimulus(name, op, -1);
   endtask

   logic [5:0] opPool [8];

   initial begin
      reset     = 1'b1;
      opcode    = 6'b0;
      mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset state", 32'(state_dbg), 0);
      checkOutput("reset ctrl", 32'(observedControls()), 32'(expectedControls(0, 1'b0, 6'b0)));
      reset = 1'b0;

      // Directed instructions (plan lengths give the unstalled latencies).
      runInstr("rtype", 6'b000000, 0, 0, 4);
      runInstr("lw", 6'b100011, 0, 0, 5);
      runInstr("sw", 6'b101011, 0, 0, 4);
      runInstr("beq", 6'b000100, 0, 0, 3);
      runInstr("j", 6'b000010, 0, 0, 3);
`ifdef MC_CTRL_ADDI_EN
      runInstr("addi", 6'b001000, 0, 0, 4);
`else
      runInstr("addi", 6'b001000, 0, 0, 2);
`endif
      runInstr("illegal", 6'b111111, 0, 0, 2);
      runInstr("lw_stall", 6'b100011, 0, 3, 8);
      runInstr("fetch_stall", 6'b000000, 2, 0, 6);
      runInstr("sw_stall", 6'b101011, 1, 2, 7);

      // Reset while stalled in MEM_WR (plan index 4 is the second MEM_WR cycle).
      buildPlan(6'b101011, 0, 3);
      applyStimulus("sw_abort", 6'b101011, 4);
      runInstr("after_abort", 6'b000100, 0, 0, 3);

      // Randomised instruction stream.
      opPool = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                 6'b000010, 6'b001000, 6'b111111, 6'b010101};
      for (int n = 0; n < 60; n++) begin
         logic [5:0] op;
         op = opPool[$urandom_range(0, 7)];
         if ($urandom_range(0, 9) == 0) op = 6'($urandom);
         runInstr($sformatf("rand%0d", n), op, $urandom_range(0, 2), $urandom_range(0, 3), 0);
      end

      mem_ready = 1'b0;
      #2;
      checkOutput("final state", 32'(state_dbg), 0);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
